// File: rtl/shift_in.sv
// shift_in: MSB-first serial-to-parallel receiver. A word is valid the cycle after its last bit; a word that completes while valid&&!ready is dropped and sets the sticky overrun.
// Optional debug ports (contents tap, dropped-word counter) are built when SHIFT_IN_DEBUG_EN is defined.
module shift_in #(
  parameter int WIDTH = 64
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       d_in,
  input  logic                       start,
  output logic [WIDTH-1:0]           d_out,
  output logic                       valid,
  input  logic                       ready,
  output logic                       busy,
  output logic                       overrun,
  output logic [$clog2(WIDTH)-1:0]   bit_count
`ifdef SHIFT_IN_DEBUG_EN
  ,
  output logic [WIDTH-1:0]           debugContents,
  output logic [15:0]                debugOverrunCount
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // The oldest bit of the shift register is never read except through the debug tap,
  // so it is only kept when that tap exists.
`ifdef SHIFT_IN_DEBUG_EN
  localparam int CONT_W = WIDTH;
`else
  localparam int CONT_W = WIDTH - 1;
`endif

  logic [CONT_W-1:0] contents;
  logic [WIDTH-1:0]  next_word;
  logic              complete;
  logic              drop;

  assign next_word = {contents[WIDTH-2:0], d_in};
  // A start edge begins a new word, so it can never complete the old one.
  assign complete  = en && !start && (bit_count == LAST_BIT);
  assign drop      = complete && valid && !ready;
  assign busy      = (bit_count != '0);

  always_ff @(posedge CLK) begin
    if (rst) begin
      contents  <= '0;
      bit_count <= '0;
    end else if (start) begin
      contents  <= CONT_W'(en & d_in);
      bit_count <= en ? CW'(1) : '0;
    end else if (en) begin
      contents  <= next_word[CONT_W-1:0];
      bit_count <= complete ? '0 : bit_count + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      d_out   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (complete && !drop) begin
        d_out <= next_word;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (start) begin
        overrun <= 1'b0;
      end else if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SHIFT_IN_DEBUG_EN
  assign debugContents = contents;

  always_ff @(posedge CLK) begin
    if (rst) begin
      debugOverrunCount <= '0;
    end else if (drop && (debugOverrunCount != 16'hFFFF)) begin
      debugOverrunCount <= debugOverrunCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_in.sv
// Randomized scoreboard bench for shift_in (WIDTH=64): a bit-queue reference model predicts
// status every cycle and the queue of words the consumer should receive.
module tb_shift_in;

  logic        CLK;
  logic        rst;
  logic        en;
  logic        d_in;
  logic        start;
  logic [63:0] d_out;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        overrun;
  logic [5:0]  bit_count;

  shift_in #(.WIDTH(64)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .en        (en),
    .d_in      (d_in),
    .start     (start),
    .d_out     (d_out),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .overrun   (overrun),
    .bit_count (bit_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 1'b0;

  // Reference model: bits of the word in progress, the held word, and words owed to the consumer.
  bit          cur_bits[$];
  logic [63:0] m_dout  = '0;
  bit          m_valid = 1'b0;
  bit          m_ovr   = 1'b0;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model(input logic e, input logic d, input logic s, input logic r, input logic rs);
    logic [63:0] w;
    bit          done;
    if (rs) begin
      cur_bits.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      exp_q.delete();
      return;
    end
    done = 1'b0;
    w    = '0;
    if (s) begin
      cur_bits.delete();
      m_ovr = 1'b0;
      if (e) cur_bits.push_back(d);
    end else if (e) begin
      cur_bits.push_back(d);
      if (cur_bits.size() == 64) begin
        foreach (cur_bits[i]) if (cur_bits[i]) w |= 64'd1 << (63 - i);
        cur_bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_dout  = w;
        m_valid = 1'b1;
        exp_q.push_back(w);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic e, input logic d, input logic s, input logic r, input logic rs);
    en = e; d_in = d; start = s; ready = r; rst = rs;
    @(posedge CLK);
    model(e, d, s, r, rs);
    #1;
  endtask

  task automatic send_word(input logic [63:0] w, input int gap_pct, input logic r, input logic r_last);
    for (int i = 63; i >= 0; i--) begin
      while ($urandom_range(99) < gap_pct) step(1'b0, 1'($urandom), 1'b0, r, 1'b0);
      step(1'b1, w[i], 1'b0, (i == 0) ? r_last : r, 1'b0);
    end
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: per-cycle status against the model, and every consumed word against the scoreboard.
  always @(negedge CLK) begin
    if (mon_on) begin
      chk("valid", valid, m_valid);
      chk("d_out", d_out, m_dout);
      chk("overrun", overrun, m_ovr);
      chk("busy", busy, cur_bits.size() != 0);
      chk("bit_count", bit_count, cur_bits.size());
      if (valid && ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL consume: word %h taken with none expected", d_out);
        end else begin
          chk("consumed_word", d_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] a5;
    logic [63:0] sh;
    en = 0; d_in = 0; start = 0; ready = 0; rst = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    mon_on = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("reset_d_out", d_out, 64'd0);
    chk("reset_valid", valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    chk("reset_bit_count", bit_count, 0);

    // Basic capture
    send_word(64'hDEADBEEF01234567, 0, 1'b0, 1'b0);
    chk("basic_d_out", d_out, 64'hDEADBEEF01234567);
    chk("basic_valid", valid, 1);
    chk("basic_busy", busy, 0);
    chk("basic_bit_count", bit_count, 0);
    drain();
    chk("drain_valid", valid, 0);

    // Enable gaps
    send_word(64'hDEADBEEF01234567, 60, 1'b0, 1'b0);
    chk("gap_d_out", d_out, 64'hDEADBEEF01234567);
    chk("gap_valid", valid, 1);
    drain();

    // Overrun, then start clears it but keeps the held word
    send_word(64'h1111111111111111, 0, 1'b0, 1'b0);
    send_word(64'h2222222222222222, 20, 1'b0, 1'b0);
    chk("ovr_d_out", d_out, 64'h1111111111111111);
    chk("ovr_flag", overrun, 1);
    step(0, 0, 1, 0, 0);
    chk("start_clears_ovr", overrun, 0);
    chk("start_keeps_valid", valid, 1);

    // Ready exactly on the completion edge of the next word
    send_word(64'h3333333333333333, 0, 1'b0, 1'b1);
    chk("corner_d_out", d_out, 64'h3333333333333333);
    chk("corner_valid", valid, 1);
    chk("corner_overrun", overrun, 0);
    step(0, 0, 0, 1, 0);
    chk("corner_valid_falls", valid, 0);

    // Alignment: start together with the first bit of the new word
    a5 = 64'hA5A5A5A5A5A5A5A5;
    for (int i = 0; i < 10; i++) step(1, 1'($urandom), 0, 0, 0);
    step(1, a5[63], 1, 0, 0);
    chk("align_bit_count", bit_count, 1);
    for (int i = 62; i >= 0; i--) step(1, a5[i], 0, 0, 0);
    chk("align_d_out", d_out, 64'hA5A5A5A5A5A5A5A5);
    chk("align_valid", valid, 1);
    drain();

    // Reset mid-word with a held word and overrun pending
    send_word(64'($urandom) << 32 | 64'($urandom), 0, 1'b0, 1'b0);
    send_word(64'($urandom), 10, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1, 1'($urandom), 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_d_out", d_out, 64'd0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_count", bit_count, 0);

    // Continuous stream with ready tied high: nothing lost
    for (int k = 0; k < 3; k++) send_word({32'($urandom), 32'($urandom)}, 0, 1'b1, 1'b1);
    chk("stream_overrun", overrun, 0);

    // Random phases: rare ready (provokes overruns), then frequent ready
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(199) == 0),
           1'($urandom_range(99) == 0), 1'($urandom_range(999) == 0));
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom_range(199) == 0),
           1'($urandom_range(1) == 0), 1'($urandom_range(999) == 0));

    // Loopback from a 64-bit MSB-first serial shifter loaded at reset
    sh = 64'h0123456789ABCDEF;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      step(1, sh[63], 0, 0, 0);
      sh = sh << 1;
    end
    chk("loop_d_out", d_out, 64'h0123456789ABCDEF);
    chk("loop_valid", valid, 1);
    drain();
    drain();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_in.md
# shift_in

Serial-to-parallel receiver: the receive-side counterpart of the 64-bit MSB-first serial shifter in the ok_spi path. It samples one serial bit per enabled clock into a WIDTH-bit shift register, MSB first. On each complete word it transfers the word to a holding register and presents it with a valid/ready handshake. A frame-alignment input discards partial words, and a sticky flag records words lost to back-pressure.

## Interface

Parameters:
- WIDTH, 64, word length in bits. Must be at least 2.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  bit strobe; d_in is sampled on edges where en=1.
- d_in  input  1  serial data, MSB of the word first.
- start  input  1  frame alignment; discards any partial word.
- d_out  output  WIDTH  holding register: last completed word.
- valid  output  1  d_out holds an unconsumed word.
- ready  input  1  consumer accepts d_out on an edge where valid=1 and ready=1.
- busy  output  1  a partial word is in progress (bit count != 0).
- overrun  output  1  sticky: a completed word was dropped.
- bit_count  output  clog2(WIDTH)  bits received in the current word.

## Operation

- Shift register `contents`, WIDTH bits. On en=1: contents <= {contents[WIDTH-2:0], d_in}, and bit_count increments. The first bit received ends up at d_out[WIDTH-1].
- Implicit states, derived from bit_count:
  - IDLE: bit_count=0.
  - SHIFTING: bit_count in 1..WIDTH-1.
- Word completion happens on an edge with en=1 and bit_count=WIDTH-1:
  - bit_count wraps to 0.
  - The full word {contents[WIDTH-2:0], d_in} is offered to the holding register.
- Holding register rules on a completion edge:
  - valid=0, or valid=1 with ready=1: d_out <= new word and valid <= 1.
  - valid=1 with ready=0: new word dropped, d_out unchanged, overrun <= 1.
- Without a completion, an edge with valid=1 and ready=1 clears valid. d_out retains its old value.
- Behaviour of start=1:
  - bit_count <= 0 and contents <= 0.
  - If en=1 on the same edge, d_in is taken as the first bit of the new word: contents <= {0..., d_in} and bit_count <= 1.
  - start clears overrun.
  - start does not affect d_out or valid.
- Bits sampled while en=0 are ignored. Gaps of any length between enabled bits are legal.
- busy = (bit_count != 0).

## Timing

- Reset values: contents=0, d_out=0, valid=0, overrun=0, busy=0, bit_count=0.
- rst has priority over start, en and ready. Reset mid-word discards the partial word and any held word.
- Latency: valid and d_out update on the same edge that samples the WIDTH-th bit, so they are visible in the following cycle.
- With en high continuously and ready tied high, one word is produced every WIDTH cycles and none is lost.
- The consumer has WIDTH-1 enabled-bit times after valid rises to accept the word before an overrun can occur.
- overrun stays high until rst or start.

## Configuration

- SHIFT_IN_DEBUG_EN defined:
  - Adds output port debugContents [WIDTH-1:0], driven combinationally from `contents`.
  - Adds output port debugOverrunCount [15:0]: increments on each dropped word, saturates at 0xFFFF, cleared by rst only.
- SHIFT_IN_DEBUG_EN undefined: neither port exists and neither the logic nor the counter is synthesized. All other behaviour is identical.

## Test plan

- Basic capture:
  - Stimulus: WIDTH=64, rst, then 64 consecutive en cycles shifting 0xDEADBEEF01234567 MSB first, ready=0.
  - Response: valid=1 and d_out=0xDEADBEEF01234567 one cycle after the 64th sample; busy=0; bit_count=0.
- Enable gaps:
  - Stimulus: the same word with en toggling 1,0,0,1... (random gaps).
  - Response: identical d_out. valid rises only after the 64th enabled sample. bit_count equals the number of enabled samples taken so far.
- Overrun:
  - Stimulus: complete word 0x1111111111111111 with ready=0, then complete 0x2222222222222222 with ready=0.
  - Response: d_out stays 0x1111111111111111, overrun=1. A subsequent start clears overrun but leaves valid=1.
- Handshake corner:
  - Stimulus: ready=1 on the exact edge a second word completes.
  - Response: d_out takes the new word, valid stays 1, overrun stays 0.
  - Stimulus: ready=1 on a non-completion edge.
  - Response: valid falls next cycle.
- Alignment and reset:
  - Stimulus: shift 10 bits, assert start together with en carrying bit 63 of 0xA5A5A5A5A5A5A5A5, then send the remaining 63 bits.
  - Response: d_out=0xA5A5A5A5A5A5A5A5.
  - Stimulus: rst asserted after 30 bits.
  - Response: every output returns to its reset value.
- Loopback:
  - Stimulus: connect the ok_spi serial shifter's serial output to d_in. Load 0x0123456789ABCDEF into the shifter via its reset, then strobe both blocks' en for 64 cycles.
  - Response: d_out=0x0123456789ABCDEF, valid=1.
